sakebi_xmii_rx: RTL and testbench
=================================

// Module: sakebi_xmii_rx
// PURPOSE
//  Parametrised MII/RMII frame receiver with an AXI-Stream byte output. Detects preamble/SFD,
//  assembles LSB-first symbols into bytes, and marks frame end (TLAST) and frame errors (TUSER).
//  Output is buffered in an internal FIFO. Supports 100 Mb/s and 10 Mb/s symbol rates.
//  Sits between the PHY pins (synchronous to i_axis_ACLK) and the packet parser.
// PARAMETERS
//  DW          2     symbol width: 2 = RMII, 4 = MII; no other value is legal
//  FIFO_DEPTH  16    output FIFO entries, power of 2, >= 4
//  MAX_LEN     1522  max bytes per frame after SFD; longer frames are errored
// PORTS
//  i_axis_ACLK     in   1     single clock; PHY signals are synchronous to it
//  i_axis_ARESET   in   1     synchronous, active-high reset
//  i_xmii_CRS_DV   in   1     carrier/data valid
//  i_xmii_RXD      in   DW    receive symbol
//  i_xmii_RX_ER    in   1     PHY receive error
//  i_slow          in   1     1 = 10 Mb/s: one symbol every 10 clocks; 0 = one symbol per clock
//  o_axis_TVALID   out  1     AXIS valid
//  i_axis_TREADY   in   1     AXIS ready
//  o_axis_TDATA    out  8     received byte
//  o_axis_TLAST    out  1     last byte of frame
//  o_axis_TUSER    out  1     frame bad; meaningful only with TLAST=1
//  o_drop_cnt      out  16    count of frames truncated by FIFO overflow; saturates at 0xFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, o_drop_cnt=0, slow divider=0. Reset mid-frame
//   discards all state; no terminator is emitted for the interrupted frame.
//  Symbol strobe: i_slow=0 -> every cycle. i_slow=1 -> divider 0..9; strobe when divider==0;
//   divider forced to 0 on CRS_DV rising edge. CRS_DV/RXD/RX_ER are evaluated only on strobe.
//  Patterns: preamble symbol is 2'b01 (DW=2) or 4'b0101 (DW=4); SFD symbol is 2'b11 or 4'b1101.
//  FSM, transitions on strobe:
//   IDLE: CRS_DV=1 and preamble symbol -> PRE
//   PRE:  CRS_DV=0 -> IDLE; SFD symbol -> DATA; preamble symbol -> stay; any other symbol -> IDLE
//   DATA: bytes assembled LSB-first; DW=2 takes 4 symbols/byte, DW=4 takes 2.
//         CRS_DV=0 -> END. Overflow -> DROP.
//   END:  staged byte pushed with TLAST=1 -> IDLE (one clock)
//   DROP: wait for CRS_DV=0, then push terminator {TDATA=0x00,TLAST=1,TUSER=1} as soon as not full;
//         o_drop_cnt++ -> IDLE
//  Staging: each completed byte is held in a stage register; it is pushed when the next byte
//   completes, or at END with TLAST=1. A frame with zero complete bytes emits nothing.
//  Error (TUSER=1 on the TLAST beat) if any of: RX_ER=1 during DATA; a partial byte at CRS_DV fall
//   (dribble; the partial byte is discarded); byte count > MAX_LEN (bytes beyond MAX_LEN not pushed).
//  Overflow: push needed while FIFO full and no pop in the same cycle. If no byte of the frame was
//   yet pushed, the frame is silently dropped (cnt++, no terminator). Otherwise go to DROP.
//  FIFO: width 10 {TUSER,TLAST,TDATA}. Simultaneous push+pop while full is legal, not an overflow.
//   TVALID rises 1 clock after a push into an empty FIFO. Pop when TVALID&TREADY.
//   TDATA/TLAST/TUSER are held stable while TVALID=1 and TREADY=0.
//  Latency (i_slow=0, DW=2, TREADY=1): byte N appears 4 clocks after its last symbol completes
//   byte N+1's symbols plus 1; the last byte appears 2 clocks after the CRS_DV=0 strobe.
// TESTING
//  RMII DW=2, fast, TREADY=1: 7x01, SFD 11, bytes 0xD5,0x3C,0xA7, CRS_DV=0 -> D5,3C,A7 with TLAST on A7, TUSER=0
//  MII DW=4, i_slow=1: each nibble held 10 clocks, payload 0x12,0x34 -> 12,34 exactly once each; TLAST on 34
//  Dribble: 3 bytes then 1 extra dibit, CRS_DV=0 -> 3 beats, last has TLAST=1,TUSER=1
//  RX_ER pulse during byte 2 of 5 -> 5 beats, TUSER=1 only on beat 5
//  TREADY=0, FIFO_DEPTH=4, 10-byte frame -> 4 bytes held + terminator 0x00/TLAST/TUSER once drained; o_drop_cnt=1
//  Reset asserted mid-DATA, then a clean 2-byte frame -> only the 2 new bytes emitted, TLAST on 2nd

Source files
------------

// File: rtl/sakebi_xmii_rx_if.sv
// AXI-Stream byte channel carrying received frame bytes to the packet parser.
interface sakebi_xmii_rx_if;
   logic       TVALID;
   logic       TREADY;
   logic [7:0] TDATA;
   logic       TLAST;
   logic       TUSER;

   modport master (output TVALID, TDATA, TLAST, TUSER, input TREADY);
   modport slave  (input TVALID, TDATA, TLAST, TUSER, output TREADY);
endinterface

// File: rtl/sakebi_xmii_rx.sv
// MII/RMII frame receiver: preamble/SFD detect, LSB-first byte assembly, staged push into an
// output FIFO with TLAST/TUSER marking, overflow handling and a saturating drop counter.
module sakebi_xmii_rx #(
   parameter int DW         = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_LEN    = 1522
) (
   input  logic                  i_axis_ACLK,
   input  logic                  i_axis_ARESET,
   input  logic                  i_xmii_CRS_DV,
   input  logic [DW-1:0]         i_xmii_RXD,
   input  logic                  i_xmii_RX_ER,
   input  logic                  i_slow,
   sakebi_xmii_rx_if.master      m_axis,
   output logic [15:0]           o_drop_cnt
);
   localparam int SPB = 8 / DW;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [DW-1:0] PRE_SYM = DW'(DW == 2 ? 4'b0001 : 4'b0101);
   localparam logic [DW-1:0] SFD_SYM = DW'(DW == 2 ? 4'b0011 : 4'b1101);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_END, S_DROP} state_e;

   state_e          state_q, state_d;
   logic [3:0]      div_q, div_d, div_eff;
   logic            crs_prev_q;
   logic [7:0]      sh_q, sh_d, stage_q, stage_d, new_byte;
   logic            stage_vld_q, stage_vld_d, err_q, err_d, pushed_any_q, pushed_any_d;
   logic            term_q, term_d, low_seen_q, low_seen_d;
   logic [1:0]      sym_cnt_q, sym_cnt_d;
   logic [15:0]     byte_cnt_q, byte_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [9:0]      mem_q [FIFO_DEPTH];
   logic [9:0]      push_data, rd_word;
   logic            crs, strobe, byte_done, push, fifo_we, pop, full, can_push, ovf;
   logic            tvalid, drop_done, drop_inc;

   assign crs       = i_xmii_CRS_DV;
   // A carrier rising edge realigns the 10 Mb/s divider so the first symbol is sampled at once.
   assign div_eff   = (crs & ~crs_prev_q) ? 4'd0 : div_q;
   assign strobe    = ~i_slow | (div_eff == 4'd0);
   assign div_d     = (div_eff == 4'd9) ? 4'd0 : div_eff + 4'd1;
   assign new_byte  = {i_xmii_RXD, sh_q[7:DW]};
   assign byte_done = (state_q == S_DATA) & strobe & crs & (sym_cnt_q == 2'(SPB - 1));

   assign tvalid    = (cnt_q != '0);
   assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign pop       = tvalid & m_axis.TREADY;
   assign can_push  = ~full | pop;
   assign fifo_we   = push & can_push;
   assign ovf       = push & ~can_push;
   assign drop_done = (state_q == S_DROP) & (low_seen_q | (strobe & ~crs)) & (~term_q | can_push);

   always_ff @(posedge i_axis_ACLK) begin
      if (i_axis_ARESET) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         crs_prev_q   <= 1'b0;
         sh_q         <= '0;
         stage_q      <= '0;
         stage_vld_q  <= 1'b0;
         err_q        <= 1'b0;
         pushed_any_q <= 1'b0;
         term_q       <= 1'b0;
         low_seen_q   <= 1'b0;
         sym_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         drop_cnt_q   <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         crs_prev_q   <= crs;
         sh_q         <= sh_d;
         stage_q      <= stage_d;
         stage_vld_q  <= stage_vld_d;
         err_q        <= err_d;
         pushed_any_q <= pushed_any_d;
         term_q       <= term_d;
         low_seen_q   <= low_seen_d;
         sym_cnt_q    <= sym_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge i_axis_ACLK) begin
      if (fifo_we) mem_q[wr_q] <= push_data;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (strobe && crs && i_xmii_RXD == PRE_SYM) state_d = S_PRE;
         S_PRE: if (strobe) begin
            if (!crs)                         state_d = S_IDLE;
            else if (i_xmii_RXD == SFD_SYM)   state_d = S_DATA;
            else if (i_xmii_RXD != PRE_SYM)   state_d = S_IDLE;
         end
         S_DATA: if (ovf) state_d = S_DROP;
                 else if (strobe && !crs) state_d = S_END;
         S_END:  state_d = (ovf && pushed_any_q) ? S_DROP : S_IDLE;
         S_DROP: if (drop_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         S_DATA: if (byte_done && byte_cnt_q < 16'(MAX_LEN) && stage_vld_q) begin
            push      = 1'b1;
            push_data = {2'b00, stage_q};
         end
         S_END: if (stage_vld_q) begin
            push      = 1'b1;
            push_data = {err_q, 1'b1, stage_q};
         end
         S_DROP: if (drop_done && term_q) begin
            push      = 1'b1;
            push_data = 10'h300;
         end
         default: ;
      endcase
   end

   always_comb begin
      sh_d         = sh_q;
      stage_d      = stage_q;
      stage_vld_d  = stage_vld_q;
      err_d        = err_q;
      pushed_any_d = pushed_any_q;
      term_d       = term_q;
      low_seen_d   = low_seen_q;
      sym_cnt_d    = sym_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      drop_inc     = 1'b0;
      if (state_q == S_IDLE || state_q == S_PRE) begin
         sym_cnt_d    = '0;
         byte_cnt_d   = '0;
         stage_vld_d  = 1'b0;
         err_d        = 1'b0;
         pushed_any_d = 1'b0;
         term_d       = 1'b0;
         low_seen_d   = 1'b0;
      end
      if (state_q == S_DATA && strobe) begin
         if (crs) begin
            sh_d      = new_byte;
            sym_cnt_d = (sym_cnt_q == 2'(SPB - 1)) ? 2'd0 : sym_cnt_q + 2'd1;
            if (i_xmii_RX_ER) err_d = 1'b1;
            // Bytes past MAX_LEN are counted as an error but never staged.
            if (byte_done) begin
               if (byte_cnt_q < 16'(MAX_LEN)) begin
                  byte_cnt_d  = byte_cnt_q + 16'd1;
                  stage_d     = new_byte;
                  stage_vld_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end else if (sym_cnt_q != '0) begin
            err_d = 1'b1;
         end
      end
      if (fifo_we) pushed_any_d = 1'b1;
      // Nothing of the frame reached the FIFO yet: drop it without a terminator.
      if (ovf) begin
         if (pushed_any_q) begin
            term_d     = 1'b1;
            low_seen_d = (state_q == S_END);
         end else begin
            drop_inc = 1'b1;
         end
      end
      if (state_q == S_DROP && strobe && !crs) low_seen_d = 1'b1;
      if (state_q == S_DROP && fifo_we) drop_inc = 1'b1;
      drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_comb begin
      wr_d  = wr_q + AW'(fifo_we);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + (AW+1)'(fifo_we) - (AW+1)'(pop);
   end

   assign rd_word       = mem_q[rd_q];
   assign m_axis.TVALID = tvalid;
   assign m_axis.TDATA  = tvalid ? rd_word[7:0] : 8'h00;
   assign m_axis.TLAST  = tvalid & rd_word[8];
   assign m_axis.TUSER  = tvalid & rd_word[9];
   assign o_drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_sakebi_xmii_rx.sv
// Directed bench: RMII instance (FIFO_DEPTH=4, MAX_LEN=8) and MII 10 Mb/s instance.
module tb_sakebi_xmii_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_crs = 1'b0, r_er = 1'b0, m_crs = 1'b0, m_er = 1'b0;
   logic [1:0]  r_rxd = '0;
   logic [3:0]  m_rxd = '0;
   logic [15:0] r_drop, m_drop;
   int          n_run = 0, n_fail = 0;
   logic [9:0]  q_r[$], q_m[$], exp_q[$];

   sakebi_xmii_rx_if if_r();
   sakebi_xmii_rx_if if_m();

   sakebi_xmii_rx #(.DW(2), .FIFO_DEPTH(4), .MAX_LEN(8)) u_rmii (
      .i_axis_ACLK(clk), .i_axis_ARESET(rst), .i_xmii_CRS_DV(r_crs), .i_xmii_RXD(r_rxd),
      .i_xmii_RX_ER(r_er), .i_slow(1'b0), .m_axis(if_r), .o_drop_cnt(r_drop));

   sakebi_xmii_rx #(.DW(4), .FIFO_DEPTH(16), .MAX_LEN(1522)) u_mii (
      .i_axis_ACLK(clk), .i_axis_ARESET(rst), .i_xmii_CRS_DV(m_crs), .i_xmii_RXD(m_rxd),
      .i_xmii_RX_ER(m_er), .i_slow(1'b1), .m_axis(if_m), .o_drop_cnt(m_drop));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (if_r.TVALID && if_r.TREADY) q_r.push_back({if_r.TUSER, if_r.TLAST, if_r.TDATA});
      if (if_m.TVALID && if_m.TREADY) q_m.push_back({if_m.TUSER, if_m.TLAST, if_m.TDATA});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beats(input string tag, input bit mii);
      int n;
      logic [9:0] b;
      n = mii ? q_m.size() : q_r.size();
      chk({tag, ".count"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         b = 10'h3FF;
         if (i < n) b = mii ? q_m[i] : q_r[i];
         chk($sformatf("%s.beat%0d", tag, i), 32'(b), 32'(exp_q[i]));
      end
   endtask

   task automatic r_sym(input logic c, input logic [1:0] d, input logic e);
      @(negedge clk);
      r_crs = c; r_rxd = d; r_er = e;
   endtask

   task automatic r_pre();
      repeat (7) r_sym(1'b1, 2'b01, 1'b0);
      r_sym(1'b1, 2'b11, 1'b0);
   endtask

   task automatic r_byte(input logic [7:0] b, input int er_sym);
      for (int i = 0; i < 4; i++) r_sym(1'b1, b[2*i +: 2], (i == er_sym));
   endtask

   task automatic r_end();
      r_sym(1'b0, 2'b00, 1'b0);
      repeat (8) @(negedge clk);
   endtask

   task automatic m_sym(input logic c, input logic [3:0] d);
      @(negedge clk);
      m_crs = c; m_rxd = d;
      repeat (9) @(negedge clk);
   endtask

   initial begin
      if_r.TREADY = 1'b1;
      if_m.TREADY = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.r_tvalid", 32'(if_r.TVALID), 32'd0);
      chk("rst.m_tvalid", 32'(if_m.TVALID), 32'd0);
      chk("rst.r_beat", 32'({if_r.TUSER, if_r.TLAST, if_r.TDATA}), 32'd0);
      chk("rst.r_drop", 32'(r_drop), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic RMII frame plus last-byte latency
      q_r.delete();
      r_pre();
      r_byte(8'hD5, -1); r_byte(8'h3C, -1); r_byte(8'hA7, -1);
      r_sym(1'b0, 2'b00, 1'b0);
      @(negedge clk);
      chk("lat.end_cycle_tvalid", 32'(if_r.TVALID), 32'd0);
      @(negedge clk);
      chk("lat.last_tvalid", 32'(if_r.TVALID), 32'd1);
      chk("lat.last_word", 32'({if_r.TUSER, if_r.TLAST, if_r.TDATA}), 32'h1A7);
      repeat (6) @(negedge clk);
      exp_q.delete();
      exp_q.push_back(10'h0D5); exp_q.push_back(10'h03C); exp_q.push_back(10'h1A7);
      chk_beats("rmii", 1'b0);

      // MII at 10 Mb/s, nibbles held 10 clocks
      q_m.delete();
      repeat (7) m_sym(1'b1, 4'h5);
      m_sym(1'b1, 4'hD);
      m_sym(1'b1, 4'h2); m_sym(1'b1, 4'h1); m_sym(1'b1, 4'h4); m_sym(1'b1, 4'h3);
      m_sym(1'b0, 4'h0);
      repeat (5) @(negedge clk);
      exp_q.delete();
      exp_q.push_back(10'h012); exp_q.push_back(10'h134);
      chk_beats("mii_slow", 1'b1);

      // Dribble symbol
      q_r.delete();
      r_pre();
      r_byte(8'h11, -1); r_byte(8'h22, -1); r_byte(8'h33, -1);
      r_sym(1'b1, 2'b10, 1'b0);
      r_end();
      exp_q.delete();
      exp_q.push_back(10'h011); exp_q.push_back(10'h022); exp_q.push_back(10'h333);
      chk_beats("dribble", 1'b0);

      // RX_ER pulse inside byte 2
      q_r.delete();
      r_pre();
      r_byte(8'h81, -1); r_byte(8'h42, 1); r_byte(8'h24, -1); r_byte(8'h18, -1); r_byte(8'hFF, -1);
      r_end();
      exp_q.delete();
      exp_q.push_back(10'h081); exp_q.push_back(10'h042); exp_q.push_back(10'h024);
      exp_q.push_back(10'h018); exp_q.push_back(10'h3FF);
      chk_beats("rx_er", 1'b0);

      // Exactly MAX_LEN bytes is clean
      q_r.delete();
      r_pre();
      for (int k = 0; k < 8; k++) r_byte(8'(8'h10 + k), -1);
      r_end();
      exp_q.delete();
      for (int k = 0; k < 7; k++) exp_q.push_back(10'(10'h010 + k));
      exp_q.push_back(10'h117);
      chk_beats("maxlen_eq", 1'b0);

      // MAX_LEN+1 bytes: the extra byte is dropped and the frame flagged
      q_r.delete();
      r_pre();
      for (int k = 0; k < 9; k++) r_byte(8'(8'h20 + k), -1);
      r_end();
      exp_q.delete();
      for (int k = 0; k < 7; k++) exp_q.push_back(10'(10'h020 + k));
      exp_q.push_back(10'h327);
      chk_beats("maxlen_over", 1'b0);
      chk("maxlen.drop", 32'(r_drop), 32'd0);

      // FIFO overflow with TREADY low
      q_r.delete();
      if_r.TREADY = 1'b0;
      r_pre();
      for (int k = 1; k <= 10; k++) r_byte(8'(k), -1);
      r_end();
      chk("ovf.hold_tvalid", 32'(if_r.TVALID), 32'd1);
      chk("ovf.hold_word", 32'({if_r.TUSER, if_r.TLAST, if_r.TDATA}), 32'h001);
      chk("ovf.drop_before", 32'(r_drop), 32'd0);
      if_r.TREADY = 1'b1;
      repeat (10) @(negedge clk);
      exp_q.delete();
      for (int k = 1; k <= 4; k++) exp_q.push_back(10'(k));
      exp_q.push_back(10'h300);
      chk_beats("ovf", 1'b0);
      chk("ovf.drop_after", 32'(r_drop), 32'd1);

      // Reset mid-frame, then a clean 2-byte frame
      q_r.delete();
      if_r.TREADY = 1'b0;
      r_pre();
      r_byte(8'h55, -1); r_byte(8'h66, -1); r_byte(8'h77, -1);
      r_sym(1'b1, 2'b01, 1'b0);
      chk("rstmid.pre_tvalid", 32'(if_r.TVALID), 32'd1);
      @(negedge clk);
      rst = 1'b1; r_crs = 1'b1; r_rxd = 2'b00;
      repeat (2) @(negedge clk);
      chk("rstmid.in_rst_tvalid", 32'(if_r.TVALID), 32'd0);
      rst = 1'b0; r_crs = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid.post_tvalid", 32'(if_r.TVALID), 32'd0);
      chk("rstmid.drop_cleared", 32'(r_drop), 32'd0);
      if_r.TREADY = 1'b1;
      r_pre();
      r_byte(8'h9A, -1); r_byte(8'hBC, -1);
      r_end();
      exp_q.delete();
      exp_q.push_back(10'h09A); exp_q.push_back(10'h1BC);
      chk_beats("rstmid", 1'b0);
      chk("rstmid.m_drop", 32'(m_drop), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
